// File: rtl/decoder_3to8_pulse_pkg.sv
// Shared types and defaults for the registered 3-to-8 pulse decoder and the
// matching encoder-side benches.
package decoder_3to8_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } dec_state_e;

  localparam int DEF_PULSE_W = 4;
  localparam int DEF_GAP_W   = 1;
  localparam int DEF_CNT_W   = 4;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'b1 << code;
  endfunction

endpackage

// File: rtl/decoder_3to8_comb.sv
// Combinational 3-to-8 one-hot decode with enable; all-zero when disabled.
module decoder_3to8_comb
  import decoder_3to8_pulse_pkg::*;
(
  input  logic       en_i,
  input  logic [2:0] code_i,
  output logic [7:0] y_o
);

  assign y_o = en_i ? onehot8(code_i) : 8'h00;

endmodule

// File: rtl/decoder_3to8_pulse.sv
// Accepts a 3-bit code over valid/ready, drives the matching one-hot line for
// PULSE_W cycles, then holds an all-zero gap of GAP_W cycles before the next.
module decoder_3to8_pulse
  import decoder_3to8_pulse_pkg::*;
#(
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  output logic [7:0] y,
  output logic       busy,
  output logic       done
);

  if (PULSE_W < 1 || GAP_W < 0 || PULSE_W > 2**CNT_W || GAP_W > 2**CNT_W) begin : g_param_err
    $error("decoder_3to8_pulse: illegal PULSE_W/GAP_W/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  dec_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic [7:0]       dec_y;

  assign in_ready = enable && (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  // The decode is captured into y_q on accept, so later code changes are ignored.
  decoder_3to8_comb u_dec (
    .en_i   (accept),
    .code_i (code),
    .y_o    (dec_y)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
          y_d     = dec_y;
          busy_d  = 1'b1;
        end
      end
      PULSE: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          y_d     = 8'h00;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          y_d    = 8'h00;
          done_d = 1'b1;
          if (GAP_W > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      GAP: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        y_d     = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
